cv32e40p_x_offload_tracker: RTL and testbench

Parametrised successor to the single-bit x-interface dispatcher in the cv32e40p ID stage. Tracks up to `MAX_OUTSTANDING` offloaded instructions by ID, accepts out-of-order results matched by ID, and issues a registered commit for every issue handshake. Keeps a register scoreboard for RAW/WAW hazards and drives the core stall and illegal-instruction outputs.

---
 rtl/cv32e40p_x_offload_tracker.sv | 193 +++++++++++++++++++
 tb/tb_cv32e40p_x_offload_tracker.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_x_offload_tracker.sv
// ---------------------------------------------------------------------------
// cv32e40p_x_offload_tracker
//
// Tracks instructions offloaded over the x-interface. It issues ID-tagged
// requests, registers a commit one cycle after every issue handshake, and
// retires in-flight entries when results come back in any order, matched by
// ID. A 32-entry register scoreboard guards RAW hazards on core instructions
// and WAW hazards on offloaded instructions. The module drives the ID-stage
// stall and illegal-instruction outputs.
//
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high. x_issue_valid_o depends only on inputs and state, never on
// x_issue_ready_i. Once raised it holds while its inputs hold. The result
// channel is always ready.
//
// Ports
//   clk_i, rst_ni                 clock, async active-low reset
//   x_offload_cand_i              ID-stage instruction is an offload candidate
//   x_branch_or_jump_i            branch/jump pending, hold off issue
//   id_ready_i                    ID stage advances (clears offloaded flag)
//   x_waddr_id_i                  rd of the ID-stage instruction
//   x_rs_addr_i, x_regs_used_i    source registers / used flags
//   x_issue_*                     issue request/response
//   x_commit_*                    registered commit channel
//   x_result_*                    result channel
//   x_stall_o, x_illegal_insn_o   core control
//   x_outstanding_o               number of valid table entries
//   x_result_orphan_o             result ID matched no entry
// ---------------------------------------------------------------------------
module cv32e40p_x_offload_tracker #(
  parameter int ID_WIDTH        = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int NUM_RS          = 3,
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  x_offload_cand_i,
  input  logic                  x_branch_or_jump_i,
  input  logic                  id_ready_i,
  input  logic [4:0]            x_waddr_id_i,
  input  logic [NUM_RS*5-1:0]   x_rs_addr_i,
  input  logic [NUM_RS-1:0]     x_regs_used_i,
  output logic                  x_issue_valid_o,
  input  logic                  x_issue_ready_i,
  output logic [ID_WIDTH-1:0]   x_issue_req_id_o,
  output logic [NUM_RS-1:0]     x_issue_req_rs_valid_o,
  input  logic                  x_issue_resp_accept_i,
  input  logic                  x_issue_resp_writeback_i,
  output logic                  x_commit_valid_o,
  output logic [ID_WIDTH-1:0]   x_commit_id_o,
  output logic                  x_commit_kill_o,
  input  logic                  x_result_valid_i,
  output logic                  x_result_ready_o,
  input  logic [ID_WIDTH-1:0]   x_result_id_i,
  input  logic [4:0]            x_result_rd_i,
  input  logic                  x_result_we_i,
  output logic                  x_stall_o,
  output logic                  x_illegal_insn_o,
  output logic [CNT_W-1:0]      x_outstanding_o,
  output logic                  x_result_orphan_o
);

  // State
  logic [31:0]                r_sb;
  logic [MAX_OUTSTANDING-1:0] r_tbl_valid;
  logic [ID_WIDTH-1:0]        r_tbl_id [MAX_OUTSTANDING];
  logic [ID_WIDTH-1:0]        r_id;
  logic [CNT_W-1:0]           r_count;
  logic                       r_offloaded;
  logic                       r_commit_valid;
  logic [ID_WIDTH-1:0]        r_commit_id;
  logic                       r_commit_kill;

  // Combinational
  logic                       w_rd_nz;
  logic                       w_waw;
  logic                       w_full;
  logic                       w_hs;
  logic                       w_alloc;
  logic                       w_raw;
  logic [4:0]                 w_rs;
  logic [MAX_OUTSTANDING-1:0] w_alloc_oh;
  logic [MAX_OUTSTANDING-1:0] w_hit_oh;
  logic                       w_alloc_found;
  logic                       w_hit_found;
  logic                       w_hit;
  logic                       w_clr_sb;

  assign w_rd_nz = |x_waddr_id_i;
  assign w_waw   = r_sb[x_waddr_id_i] & w_rd_nz;
  // Full is judged on the registered count: a slot freed by a result this
  // cycle only becomes available next cycle.
  assign w_full  = (r_count == CNT_W'(MAX_OUTSTANDING));

  assign x_issue_valid_o  = x_offload_cand_i & ~x_branch_or_jump_i & ~r_offloaded
                          & ~w_full & ~w_waw;
  assign x_issue_req_id_o = r_id;
  assign w_hs             = x_issue_valid_o & x_issue_ready_i;
  assign w_alloc          = w_hs & x_issue_resp_accept_i & x_issue_resp_writeback_i;
  assign x_illegal_insn_o = w_hs & ~x_issue_resp_accept_i;

  // Operand validity and RAW detection share one walk over the sources.
  always_comb begin
    x_issue_req_rs_valid_o = '0;
    w_raw = 1'b0;
    w_rs  = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      w_rs = x_rs_addr_i[i*5 +: 5];
      x_issue_req_rs_valid_o[i] = (w_rs == 5'd0) | ~r_sb[w_rs];
      w_raw = w_raw | (x_regs_used_i[i] & r_sb[w_rs]);
    end
  end

  // Lowest free entry (one-hot) and lowest matching valid entry (one-hot).
  always_comb begin
    w_alloc_oh    = '0;
    w_hit_oh      = '0;
    w_alloc_found = 1'b0;
    w_hit_found   = 1'b0;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (!r_tbl_valid[i] && !w_alloc_found) begin
        w_alloc_oh[i] = 1'b1;
        w_alloc_found = 1'b1;
      end
      if (x_result_valid_i && r_tbl_valid[i] && (r_tbl_id[i] == x_result_id_i)
          && !w_hit_found) begin
        w_hit_oh[i] = 1'b1;
        w_hit_found = 1'b1;
      end
    end
  end

  assign w_hit             = |w_hit_oh;
  // The table holds only IDs; the destination comes back with the result.
  assign w_clr_sb          = w_hit & x_result_we_i & (|x_result_rd_i);
  assign x_result_ready_o  = 1'b1;
  assign x_result_orphan_o = x_result_valid_i & ~w_hit;

  assign x_stall_o = (x_issue_valid_o & ~x_issue_ready_i)
                   | (x_offload_cand_i & (x_branch_or_jump_i | w_full | w_waw) & ~r_offloaded)
                   | (~x_offload_cand_i & w_raw);

  assign x_commit_valid_o = r_commit_valid;
  assign x_commit_id_o    = r_commit_id;
  assign x_commit_kill_o  = r_commit_kill;
  assign x_outstanding_o  = r_count;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sb           <= '0;
      r_tbl_valid    <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) r_tbl_id[i] <= '0;
      r_id           <= '0;
      r_count        <= '0;
      r_offloaded    <= 1'b0;
      r_commit_valid <= 1'b0;
      r_commit_id    <= '0;
      r_commit_kill  <= 1'b0;
    end else begin
      r_commit_valid <= w_hs;
      if (w_hs) begin
        r_id          <= r_id + ID_WIDTH'(1);
        r_commit_id   <= r_id;
        r_commit_kill <= ~x_issue_resp_accept_i;
      end

      // Leaving the ID stage wins over a handshake in the same cycle.
      if (id_ready_i)  r_offloaded <= 1'b0;
      else if (w_hs)   r_offloaded <= 1'b1;

      // Alloc and hit never select the same entry (free vs. valid).
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        if (w_hit_oh[i]) r_tbl_valid[i] <= 1'b0;
        if (w_alloc && w_alloc_oh[i]) begin
          r_tbl_valid[i] <= 1'b1;
          r_tbl_id[i]    <= r_id;
        end
      end

      // WAW guard keeps the set and clear registers distinct.
      if (w_clr_sb)            r_sb[x_result_rd_i] <= 1'b0;
      if (w_alloc && w_rd_nz)  r_sb[x_waddr_id_i]  <= 1'b1;

      case ({w_alloc, w_hit})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_cv32e40p_x_offload_tracker.sv
module tb_cv32e40p_x_offload_tracker;

  localparam int IDW  = 4;
  localparam int MAXO = 4;
  localparam int NRS  = 3;
  localparam int CW   = $clog2(MAXO + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic             cand, bj, idr;
  logic [4:0]       waddr;
  logic [NRS*5-1:0] rs_addr;
  logic [NRS-1:0]   regs_used;
  logic             issue_valid, issue_ready;
  logic [IDW-1:0]   req_id;
  logic [NRS-1:0]   rs_valid;
  logic             accept, writeback;
  logic             commit_valid;
  logic [IDW-1:0]   commit_id;
  logic             commit_kill;
  logic             res_valid, res_ready;
  logic [IDW-1:0]   res_id;
  logic [4:0]       res_rd;
  logic             res_we;
  logic             stall, illegal;
  logic [CW-1:0]    outstanding;
  logic             orphan;

  cv32e40p_x_offload_tracker #(
    .ID_WIDTH(IDW), .MAX_OUTSTANDING(MAXO), .NUM_RS(NRS)
  ) dut (
    .clk_i                    (clk),
    .rst_ni                   (rst_n),
    .x_offload_cand_i         (cand),
    .x_branch_or_jump_i       (bj),
    .id_ready_i               (idr),
    .x_waddr_id_i             (waddr),
    .x_rs_addr_i              (rs_addr),
    .x_regs_used_i            (regs_used),
    .x_issue_valid_o          (issue_valid),
    .x_issue_ready_i          (issue_ready),
    .x_issue_req_id_o         (req_id),
    .x_issue_req_rs_valid_o   (rs_valid),
    .x_issue_resp_accept_i    (accept),
    .x_issue_resp_writeback_i (writeback),
    .x_commit_valid_o         (commit_valid),
    .x_commit_id_o            (commit_id),
    .x_commit_kill_o          (commit_kill),
    .x_result_valid_i         (res_valid),
    .x_result_ready_o         (res_ready),
    .x_result_id_i            (res_id),
    .x_result_rd_i            (res_rd),
    .x_result_we_i            (res_we),
    .x_stall_o                (stall),
    .x_illegal_insn_o         (illegal),
    .x_outstanding_o          (outstanding),
    .x_result_orphan_o        (orphan)
  );

  // ---------------- vector record ----------------
  typedef struct {
    logic       cand, bj, idr;
    logic [4:0] rd, rs0, rs1, rs2;
    logic [2:0] used;
    logic       rdy, acc, wb;
    logic       rv;
    logic [3:0] rid;
    logic [4:0] rrd;
    logic       rwe;
    logic       iv;
    logic [2:0] rsv;
    logic       st, ill;
    logic [2:0] out;
    logic       orph;
  } vec_t;

  function automatic vec_t mk(
    input logic cand_v, bj_v, idr_v,
    input logic [4:0] rd_v, rs0_v, rs1_v, rs2_v,
    input logic [2:0] used_v,
    input logic rdy_v, acc_v, wb_v, rv_v,
    input logic [3:0] rid_v,
    input logic [4:0] rrd_v,
    input logic rwe_v, iv_v,
    input logic [2:0] rsv_v,
    input logic st_v, ill_v,
    input logic [2:0] out_v,
    input logic orph_v);
    vec_t v;
    v.cand = cand_v; v.bj = bj_v; v.idr = idr_v;
    v.rd = rd_v; v.rs0 = rs0_v; v.rs1 = rs1_v; v.rs2 = rs2_v;
    v.used = used_v; v.rdy = rdy_v; v.acc = acc_v; v.wb = wb_v;
    v.rv = rv_v; v.rid = rid_v; v.rrd = rrd_v; v.rwe = rwe_v;
    v.iv = iv_v; v.rsv = rsv_v; v.st = st_v; v.ill = ill_v;
    v.out = out_v; v.orph = orph_v;
    return v;
  endfunction

  function automatic vec_t idle(input logic [2:0] out_v);
    return mk(0,0,1, 0, 0,0,0, 0, 0,0,0, 0,0,0,0, 0,7,0,0,out_v,0);
  endfunction

  // ---------------- scoreboard ----------------
  logic [IDW:0]   exp_q[$];   // {kill, id} of each expected commit
  logic [IDW-1:0] m_id;       // expected next issue ID
  logic           pend;       // a commit is due at this check point
  int             n_tests;
  int             n_fail;
  vec_t           vt[$];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input vec_t v);
    cand        = v.cand;  bj        = v.bj;  idr = v.idr;
    waddr       = v.rd;
    rs_addr     = {v.rs2, v.rs1, v.rs0};
    regs_used   = v.used;
    issue_ready = v.rdy;   accept    = v.acc; writeback = v.wb;
    res_valid   = v.rv;    res_id    = v.rid; res_rd = v.rrd; res_we = v.rwe;
  endtask

  // One cycle: drive after the falling edge, check 1 ns later.
  task automatic apply(input vec_t v);
    logic [IDW:0] e;
    @(negedge clk);
    drive(v);
    #1;
    check("issue_valid", int'(issue_valid), int'(v.iv));
    check("req_id",      int'(req_id),      int'(m_id));
    check("rs_valid",    int'(rs_valid),    int'(v.rsv));
    check("stall",       int'(stall),       int'(v.st));
    check("illegal",     int'(illegal),     int'(v.ill));
    check("outstanding", int'(outstanding), int'(v.out));
    check("orphan",      int'(orphan),      int'(v.orph));
    check("result_ready", int'(res_ready),  1);
    check("commit_valid", int'(commit_valid), int'(pend));
    if (commit_valid) begin
      if (exp_q.size() == 0) begin
        check("commit_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("commit_id",   int'(commit_id),   int'(e[IDW-1:0]));
        check("commit_kill", int'(commit_kill), int'(e[IDW]));
      end
    end
    pend = 1'b0;
    if (v.iv && v.rdy) begin
      exp_q.push_back({~v.acc, m_id});
      m_id = m_id + 1'b1;
      pend = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(idle(0));
    #1;
    check("rst_commit_valid", int'(commit_valid), 0);
    check("rst_outstanding",  int'(outstanding),  0);
    check("rst_issue_valid",  int'(issue_valid),  0);
    check("rst_req_id",       int'(req_id),       0);
    check("rst_result_ready", int'(res_ready),    1);
    m_id = '0;
    pend = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- test ----------------
  logic [3:0] rid_c;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_id    = '0;
    pend    = 1'b0;
    rst_n   = 1'b0;
    drive(idle(0));
    repeat (2) @(posedge clk);
    do_reset();

    // cand, bj, idr, rd, rs0,rs1,rs2, used, rdy,acc,wb, rv,rid,rrd,rwe | iv,rsv,st,ill,out,orph
    // Basic issue and RAW stall on x5
    vt.push_back(mk(0,0,0, 0, 0,0,0, 0, 0,0,0, 0,0,0,0, 0,7,0,0,0,0));
    vt.push_back(mk(1,0,1, 5, 3,0,0, 0, 1,1,1, 0,0,0,0, 1,7,0,0,0,0));
    vt.push_back(mk(0,0,0, 0, 5,0,0, 1, 0,0,0, 0,0,0,0, 0,6,1,0,1,0));
    vt.push_back(mk(0,0,0, 0, 5,0,0, 1, 0,0,0, 1,0,5,1, 0,6,1,0,1,0));
    vt.push_back(mk(0,0,0, 0, 5,0,0, 1, 0,0,0, 0,0,0,0, 0,7,0,0,0,0));
    // WAW guard on x5
    vt.push_back(mk(1,0,1, 5, 0,0,0, 0, 1,1,1, 0,0,0,0, 1,7,0,0,0,0));
    vt.push_back(mk(1,0,0, 5, 0,0,0, 0, 1,1,1, 0,0,0,0, 0,7,1,0,1,0));
    vt.push_back(mk(0,0,1, 0, 0,0,0, 0, 0,0,0, 1,1,5,1, 0,7,0,0,1,0));
    vt.push_back(idle(0));
    // Fill the table: IDs 2..5 to rd 1..4
    vt.push_back(mk(1,0,1, 1, 0,0,0, 0, 1,1,1, 0,0,0,0, 1,7,0,0,0,0));
    vt.push_back(mk(1,0,1, 2, 0,0,0, 0, 1,1,1, 0,0,0,0, 1,7,0,0,1,0));
    vt.push_back(mk(1,0,1, 3, 0,0,0, 0, 1,1,1, 0,0,0,0, 1,7,0,0,2,0));
    vt.push_back(mk(1,0,1, 4, 0,0,0, 0, 1,1,1, 0,0,0,0, 1,7,0,0,3,0));
    // Full: fifth candidate stalls, also while a result frees a slot
    vt.push_back(mk(1,0,0, 6, 1,3,4, 0, 1,1,1, 0,0,0,0, 0,0,1,0,4,0));
    vt.push_back(mk(1,0,0, 6, 1,3,4, 0, 1,1,1, 1,4,3,1, 0,0,1,0,4,0));
    // Slot free next cycle: issue and retire together, count stays 3
    vt.push_back(mk(1,0,1, 6, 1,3,4, 0, 1,1,1, 1,2,1,1, 1,2,0,0,3,0));
    vt.push_back(mk(0,0,1, 0, 1,3,4, 0, 0,0,0, 1,5,4,1, 0,3,0,0,3,0));
    vt.push_back(mk(0,0,1, 0, 1,3,4, 0, 0,0,0, 1,3,2,1, 0,7,0,0,2,0));
    vt.push_back(mk(0,0,1, 0, 0,0,0, 0, 0,0,0, 1,6,6,1, 0,7,0,0,1,0));
    vt.push_back(idle(0));
    // Rejected by coprocessor
    vt.push_back(mk(1,0,1, 7, 0,0,0, 0, 1,0,0, 0,0,0,0, 1,7,0,1,0,0));
    vt.push_back(idle(0));
    // Accept without writeback, then an orphan result
    vt.push_back(mk(1,0,1, 8, 0,0,0, 0, 1,1,0, 0,0,0,0, 1,7,0,0,0,0));
    vt.push_back(mk(0,0,1, 0, 0,0,0, 0, 0,0,0, 1,9,8,1, 0,7,0,0,0,1));
    // rd=0 writeback: entry allocated, no scoreboard mark
    vt.push_back(mk(1,0,1, 0, 0,0,0, 0, 1,1,1, 0,0,0,0, 1,7,0,0,0,0));
    vt.push_back(mk(0,0,1, 0, 0,0,0, 1, 0,0,0, 1,9,0,1, 0,7,0,0,1,0));
    vt.push_back(idle(0));
    // Issue back-pressure, then offloaded flag blocks re-issue
    vt.push_back(mk(1,0,0, 10, 0,0,0, 0, 0,1,1, 0,0,0,0, 1,7,1,0,0,0));
    vt.push_back(mk(1,0,0, 10, 0,0,0, 0, 0,1,1, 0,0,0,0, 1,7,1,0,0,0));
    vt.push_back(mk(1,0,0, 10, 0,0,0, 0, 1,1,1, 0,0,0,0, 1,7,0,0,0,0));
    vt.push_back(mk(1,0,0, 10, 0,0,0, 0, 1,1,1, 0,0,0,0, 0,7,0,0,1,0));
    vt.push_back(mk(0,0,1, 0, 0,0,0, 0, 0,0,0, 1,10,10,1, 0,7,0,0,1,0));
    vt.push_back(idle(0));
    // Branch pending
    vt.push_back(mk(1,1,1, 11, 0,0,0, 0, 1,1,1, 0,0,0,0, 0,7,1,0,0,0));
    vt.push_back(idle(0));

    foreach (vt[i]) apply(vt[i]);

    // ID wrap: issue-and-retire 16 times, crossing 15 -> 0
    for (int k = 0; k < 16; k++) begin
      rid_c = m_id;
      apply(mk(1,0,1, 12, 0,0,0, 0, 1,1,1, 0,0,0,0, 1,7,0,0,0,0));
      apply(mk(0,0,1, 0, 0,0,0, 0, 0,0,0, 1,rid_c,12,1, 0,7,0,0,1,0));
    end
    apply(idle(0));

    // Reset mid-operation: the outstanding result becomes an orphan
    rid_c = m_id;
    apply(mk(1,0,1, 13, 0,0,0, 0, 1,1,1, 0,0,0,0, 1,7,0,0,0,0));
    apply(idle(1));
    do_reset();
    apply(mk(0,0,1, 0, 0,0,0, 0, 0,0,0, 1,rid_c,13,1, 0,7,0,0,0,1));
    apply(mk(1,0,1, 13, 0,0,0, 0, 1,1,1, 0,0,0,0, 1,7,0,0,0,0));
    apply(idle(1));

    check("exp_q_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
